// File: rtl/arbitro_spi_pkg.sv
// Shared types and helpers for the SPI register-port arbiter (arbitro_spi).
package arbitro_spi_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      DRAIN = 2'd2
   } estado_t;

   // Index of the set bit of a one-hot vector (up to 8 requesters); 0 when empty.
   function automatic int onehot_to_idx(input logic [7:0] oh);
      int idx;
      idx = 0;
      for (int i = 0; i < 8; i++) begin
         idx = idx | (oh[i] ? i : 0);
      end
      return idx;
   endfunction

endpackage

// File: rtl/arbitro_spi_chk.sv
// Property checker for arbitro_spi: grant exclusivity and write gating.
module arbitro_spi_chk #(
   parameter int N_REQ       = 2,
   parameter int TIMEOUT_CYC = 1024
) (
   input logic             clk_i,
   input logic             reset_i,
   input logic [N_REQ-1:0] gnt_o,
   input logic             spi_we_o
);

   a_gnt_onehot0: assert property (@(posedge clk_i) disable iff (reset_i) $onehot0(gnt_o));

   a_we_needs_gnt: assert property (@(posedge clk_i) disable iff (reset_i) spi_we_o |-> (|gnt_o));

   a_param_range: assert property (@(posedge clk_i)
      (N_REQ >= 2) && (N_REQ <= 8) && (TIMEOUT_CYC >= 2));

endmodule

// File: rtl/rr_prioridad.sv
// Combinational round-robin picker: first set request at or above the pointer, with wrap.
module rr_prioridad #(
   parameter int N_REQ = 2,
   parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] i_req,
   input  logic [IDX_W-1:0] i_ptr,
   output logic [N_REQ-1:0] o_pick
);

   logic [IDX_W-1:0] w_idx;
   logic             w_hit;
   logic             w_found;

   // Walk the requesters in rotated order and keep only the first hit.
   always_comb begin
      o_pick  = '0;
      w_found = 1'b0;
      w_idx   = '0;
      w_hit   = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         w_idx         = IDX_W'((int'(i_ptr) + i) % N_REQ);
         w_hit         = i_req[w_idx] & ~w_found;
         o_pick[w_idx] = w_hit;
         w_found       = w_found | w_hit;
      end
   end

endmodule

// File: rtl/arbitro_spi.sv
// Round-robin, transaction-locked arbiter for the SPI register port.
// Optional grant timeout when ARBITRO_SPI_TIMEOUT_EN is defined.
module arbitro_spi
   import arbitro_spi_pkg::*;
#(
   parameter int N_REQ       = 2,
   parameter int DATA_W      = DATA_W_DEF,
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                      clk_i,
   input  logic                      reset_i,
   input  logic [N_REQ-1:0]          req_i,
   input  logic [N_REQ-1:0]          we_i,
   input  logic [N_REQ*ADDR_W-1:0]   addr_i,
   input  logic [N_REQ*DATA_W-1:0]   wdata_i,
   output logic [N_REQ-1:0]          gnt_o,
   output logic                      spi_we_o,
   output logic [ADDR_W-1:0]         spi_addr_o,
   output logic [DATA_W-1:0]         spi_wdata_o,
   input  logic                      spi_busy_i,
   input  logic [DATA_W-1:0]         spi_rdata_i,
   output logic [DATA_W-1:0]         rdata_o,
   output logic                      timeout_o
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   estado_t          r_estado;
   logic [N_REQ-1:0] r_gnt;
   logic [IDX_W-1:0] r_ptr;
   logic [N_REQ-1:0] w_req_ok;
   logic [N_REQ-1:0] w_pick;
   logic [IDX_W-1:0] w_g;
   logic [IDX_W-1:0] w_g_next;
   logic             w_expira;
   logic [ADDR_W-1:0] w_addr;
   logic [DATA_W-1:0] w_wdata;

   assign w_g      = IDX_W'(onehot_to_idx(8'(r_gnt)));
   assign w_g_next = (w_g == IDX_W'(N_REQ-1)) ? '0 : w_g + IDX_W'(1);

`ifdef ARBITRO_SPI_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC);

   logic [CNT_W-1:0] r_cnt;
   logic [N_REQ-1:0] r_block;
   logic             r_timeout;

   assign w_expira = (r_estado == GRANT) && req_i[w_g] && !spi_busy_i
                     && (r_cnt == CNT_W'(TIMEOUT_CYC-1));
   assign w_req_ok = req_i & ~r_block;
   assign timeout_o = r_timeout;

   // Idle-hold counter, per-requester block bits and the timeout pulse.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_cnt     <= '0;
         r_block   <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_timeout <= w_expira;
         r_block   <= (r_block | (w_expira ? r_gnt : '0)) & req_i;
         if ((r_estado == GRANT) && !spi_busy_i && !w_expira) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end else begin
            r_cnt <= '0;
         end
      end
   end
`else
   assign w_expira  = 1'b0;
   assign w_req_ok  = req_i;
   assign timeout_o = 1'b0;
`endif

   rr_prioridad #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_rr (
      .i_req  (w_req_ok),
      .i_ptr  (r_ptr),
      .o_pick (w_pick)
   );

   // Arbitration FSM: IDLE picks, GRANT holds until release, DRAIN waits for the SPI.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_estado <= IDLE;
         r_gnt    <= '0;
         r_ptr    <= '0;
      end else begin
         case (r_estado)
            IDLE: begin
               if (!spi_busy_i && (|w_req_ok)) begin
                  r_gnt    <= w_pick;
                  r_estado <= GRANT;
               end else begin
                  r_gnt    <= '0;
               end
            end
            GRANT: begin
               if (!req_i[w_g]) begin
                  r_gnt    <= '0;
                  r_ptr    <= w_g_next;
                  r_estado <= spi_busy_i ? DRAIN : IDLE;
               end else if (w_expira) begin
                  r_gnt    <= '0;
                  r_ptr    <= w_g_next;
                  r_estado <= IDLE;
               end else begin
                  r_gnt    <= r_gnt;
               end
            end
            DRAIN: begin
               r_gnt <= '0;
               if (!spi_busy_i) begin
                  r_estado <= IDLE;
               end else begin
                  r_estado <= DRAIN;
               end
            end
            default: begin
               r_gnt    <= '0;
               r_estado <= IDLE;
            end
         endcase
      end
   end

   // Grant-gated mux of the owner's address and data; all zero without a grant.
   always_comb begin
      w_addr  = '0;
      w_wdata = '0;
      for (int k = 0; k < N_REQ; k++) begin
         w_addr  = w_addr  | (addr_i[k*ADDR_W +: ADDR_W]  & {ADDR_W{r_gnt[k]}});
         w_wdata = w_wdata | (wdata_i[k*DATA_W +: DATA_W] & {DATA_W{r_gnt[k]}});
      end
   end

   assign gnt_o       = r_gnt;
   assign spi_we_o    = |(we_i & r_gnt);
   assign spi_addr_o  = w_addr;
   assign spi_wdata_o = w_wdata;
   assign rdata_o     = spi_rdata_i;

   arbitro_spi_chk #(.N_REQ(N_REQ), .TIMEOUT_CYC(TIMEOUT_CYC)) u_chk (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .gnt_o    (r_gnt),
      .spi_we_o (spi_we_o)
   );

endmodule

// File: doc/arbitro_spi.md
Name: arbitro_spi

Overview:
Round-robin arbiter sharing the single SPI peripheral register interface (we, addr, wdata, rdata) between N_REQ requesters, such as the sensor control FSM and the CPU bus bridge.
Grant is transaction-locked: a requester owns the SPI from grant until it drops its request and the SPI is idle.
Sits between requester FSMs and the SPI control/data registers.

Parameters:
N_REQ, 2, number of requesters (2..8)
DATA_W, 32, SPI register data width
ADDR_W, 1, SPI register address width (matches addrc)
TIMEOUT_CYC, 1024, max cycles a grant may be held with SPI idle (used only with the optional feature)

Ports:
clk_i  in  1  system clock (10 MHz)
reset_i  in  1  synchronous, active-high reset
req_i  in  N_REQ  per-requester request level; held for the whole transaction
we_i  in  N_REQ  per-requester register write enable
addr_i  in  N_REQ*ADDR_W  per-requester address, packed, requester k at [k*ADDR_W +: ADDR_W]
wdata_i  in  N_REQ*DATA_W  per-requester write data, packed likewise
gnt_o  out  N_REQ  one-hot grant
spi_we_o  out  1  muxed write enable to SPI
spi_addr_o  out  ADDR_W  muxed address to SPI
spi_wdata_o  out  DATA_W  muxed write data to SPI
spi_busy_i  in  1  high while the SPI shifts a transaction (fin_trans level)
spi_rdata_i  in  DATA_W  SPI register read data
rdata_o  out  DATA_W  spi_rdata_i, broadcast; valid only for the granted requester
timeout_o  out  1  one-cycle pulse when a grant is revoked by timeout (0 when the feature is compiled out)

Behaviour:
- Reset (synchronous, reset_i=1 at clk_i edge):
  - state=IDLE, gnt_o=0, rr pointer=0.
  - spi_we_o=0, spi_addr_o=0, spi_wdata_o=0, timeout_o=0, timeout counter=0.
  - Reset mid-transaction drops the grant immediately; the SPI is not informed.
- States: IDLE, GRANT, DRAIN.
- IDLE:
  - If any req_i, choose the first set bit searching from the rr pointer upward with wrap.
  - Register the one-hot gnt_o and go to GRANT; gnt_o is visible the cycle after req_i is sampled (latency 1).
  - If spi_busy_i=1 in IDLE, do not grant; stay in IDLE.
- GRANT:
  - spi_we_o = we_i[g]; spi_addr_o and spi_wdata_o are requester g's fields (combinational mux gated by the grant).
  - we_i from non-granted requesters is ignored.
  - On req_i[g]=0: go to IDLE if spi_busy_i=0, else go to DRAIN.
  - In both cases gnt_o clears and spi_we_o is forced 0 from the next cycle.
  - Set rr pointer = (g+1) mod N_REQ.
- DRAIN: gnt_o=0, spi_we_o=0; wait for spi_busy_i=0, then go to IDLE.
- Turnaround: at least one IDLE cycle between consecutive grants. Back-to-back requests from different requesters are served with a gap of 1 cycle minimum.
- Outside GRANT, spi_we_o=0; spi_addr_o and spi_wdata_o hold 0.
- Simultaneous requests: the rr pointer gives fairness. With N_REQ=2 and both requesting continuously, grants alternate 0,1,0,1.
- A requester dropping and re-raising req_i in the same cycle as its release loses priority to the others.
- gnt_o is never multi-hot; assertion required.

Optional Feature:
- Macro: ARBITRO_SPI_TIMEOUT_EN.
- With the macro defined:
  - A counter increments each GRANT cycle with spi_busy_i=0 and clears on spi_busy_i=1 or on grant change.
  - When the counter reaches TIMEOUT_CYC-1, revoke the grant: pulse timeout_o for 1 cycle, advance the rr pointer, go to IDLE.
  - The offending requester must drop and re-raise req_i before it can be granted again (per-requester block bit, cleared when req_i=0).
- Without the macro: no counter and no block bits; timeout_o tied 0; a grant is held indefinitely.

Decomposition:
- Package arbitro_spi_pkg holds:
  - state enum (IDLE, GRANT, DRAIN) as a 2-bit typedef;
  - default localparams for DATA_W, ADDR_W;
  - function onehot_to_idx.
- Sub-module rr_prioridad: combinational round-robin picker.
  - Inputs: req, pointer. Output: one-hot pick.
  - Reused later by the interrupt controller.

Test Plan:
- Reset: reset_i=1 for 2 cycles with req_i=2'b11 -> gnt_o=0, spi_we_o=0, state IDLE. Release reset -> gnt_o=2'b01 one cycle later.
- Single owner: req_i[1]=1, we_i[1]=1, addr=1, wdata=32'hA5A5_0001 -> after gnt_o=2'b10, spi_we_o=1, spi_addr_o=1, spi_wdata_o=32'hA5A5_0001. Requester 0 writes in the same window are ignored.
- Fairness: req_i=2'b11 held, each owner releases after 3 cycles -> grant sequence 01,10,01,10, each grant preceded by exactly 1 idle cycle.
- Drain: the owner releases while spi_busy_i=1 for 20 cycles -> gnt_o=0, spi_we_o=0 for all 20 cycles. The next grant comes 2 cycles after spi_busy_i falls (DRAIN->IDLE->GRANT).
- Busy in IDLE: spi_busy_i=1 with req_i=2'b01 -> no grant until spi_busy_i=0.
- Timeout (ARBITRO_SPI_TIMEOUT_EN, TIMEOUT_CYC=8): requester 0 holds req 10 cycles, SPI idle -> timeout_o pulses at grant cycle 8 and gnt_o moves to requester 1. Requester 0 is not regranted until its req toggles.
